dc_access: RTL and testbench

- Data-access stage between EX and MEM in the five-plus-stage MIPS pipeline.
- Registers the EX result bus and checks load/store alignment.
- Drives the data-memory request/response interface (addr_ok/data_ok handshake, variable latency).
- Raises a pipeline stall request while an access is in flight. Presents the DC-to-MEM bus plus load data, which MEM samples on its advancing edge.

---
 rtl/dc_access_pkg.sv | 46 ++++
 rtl/dc_store_lane.sv | 52 +++++
 rtl/dc_access.sv | 195 +++++++++++++++++++
 tb/tb_dc_access.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_access_pkg.sv
// Shared definitions for the DC stage: bus field offsets, exception bits,
// access-size encodings, decoded mem_op layout and FSM state type.
package dc_access_pkg;

    // EX_TO_DC bus, low fields (payload sits above EX_PAYLOAD_LO)
    localparam int unsigned EX_EXC_LO     = 0;
    localparam int unsigned EX_PC_LO      = 32;
    localparam int unsigned EX_ADDR_LO    = 64;
    localparam int unsigned EX_SDATA_LO   = 96;
    localparam int unsigned EX_MEMOP_LO   = 128;
    localparam int unsigned EX_RSVD_LO    = 136;
    localparam int unsigned EX_PAYLOAD_LO = 168;

    // DC_TO_MEM bus
    localparam int unsigned DC_EXC_LO     = 0;
    localparam int unsigned DC_BADV_LO    = 32;
    localparam int unsigned DC_PC_LO      = 64;
    localparam int unsigned DC_PAYLOAD_LO = 96;

    localparam int unsigned EXC_ADES_BIT = 14;
    localparam int unsigned EXC_ADEL_BIT = 15;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
        logic sb;
        logic sh;
        logic sw;
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } dc_state_e;

endpackage

// File: rtl/dc_store_lane.sv
// Decodes a memory op into request size, byte enables, replicated store
// data and an alignment fault flag.
module dc_store_lane
    import dc_access_pkg::*;
(
    input  mem_op_t     mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned
);

    logic is_half;
    logic is_word;
    logic unused_addr;

    assign unused_addr = ^addr[31:2];

    always_comb begin
        is_half    = mem_op.lh | mem_op.lhu | mem_op.sh;
        is_word    = mem_op.lw | mem_op.sw;
        is_load    = mem_op.lb | mem_op.lbu | mem_op.lh | mem_op.lhu | mem_op.lw;
        is_store   = mem_op.sb | mem_op.sh | mem_op.sw;
        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));

        if (is_word) begin
            size = SIZE_WORD;
        end else if (is_half) begin
            size = SIZE_HALF;
        end else begin
            size = SIZE_BYTE;
        end

        wstrb = '0;
        wdata = '0;
        if (mem_op.sb) begin
            wstrb = 4'b0001 << addr[1:0];
            wdata = {4{store_data[7:0]}};
        end else if (mem_op.sh) begin
            wstrb = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
        end else if (mem_op.sw) begin
            wstrb = 4'b1111;
            wdata = store_data;
        end
    end

endmodule

// File: rtl/dc_access.sv
// Data-access stage between EX and MEM: registers the EX result, checks
// alignment, runs the data-memory handshake and stalls while in flight.
module dc_access
    import dc_access_pkg::*;
#(
    parameter int unsigned PAYLOAD_WD = 178,
    parameter int unsigned STALL_IDX  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [7:0]              stall,
    input  logic [PAYLOAD_WD+167:0] ex_to_dc_bus,
    output logic [PAYLOAD_WD+95:0]  dc_to_mem_bus,
    output logic                    stallreq_dc,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [31:0]             data_addr,
    output logic [3:0]              data_wstrb,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata,
    output logic [31:0]             dc_rdata
);

    logic [PAYLOAD_WD-1:0] payload_q;
    mem_op_t               op_q;
    logic [31:0]           sdata_q;
    logic [31:0]           addr_q;
    logic [31:0]           pc_q;
    logic [31:0]           exc_q;

    logic        advance;
    logic        bubble;
    logic [1:0]  lane_size;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        access;
    logic        need;
    logic        issue;
    logic [31:0] exc_out;
    logic [31:0] bad_vaddr;

    dc_state_e   state;
    logic        served;
    logic [31:0] rdata_buf;

    // The 32 bits between mem_op and the payload carry nothing this stage uses.
    logic unused_inputs;
    assign unused_inputs = ^{stall, ex_to_dc_bus[EX_RSVD_LO +: 32]};

    assign advance = ~stall[STALL_IDX];
    assign bubble  = stall[STALL_IDX] & ~stall[STALL_IDX+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q <= '0;
            op_q      <= '0;
            sdata_q   <= '0;
            addr_q    <= '0;
            pc_q      <= '0;
            exc_q     <= '0;
        end else if (flush || bubble) begin
            payload_q <= '0;
            op_q      <= '0;
            sdata_q   <= '0;
            addr_q    <= '0;
            pc_q      <= '0;
            exc_q     <= '0;
        end else if (advance) begin
            payload_q <= ex_to_dc_bus[EX_PAYLOAD_LO +: PAYLOAD_WD];
            op_q      <= mem_op_t'(ex_to_dc_bus[EX_MEMOP_LO +: 8]);
            sdata_q   <= ex_to_dc_bus[EX_SDATA_LO +: 32];
            addr_q    <= ex_to_dc_bus[EX_ADDR_LO +: 32];
            pc_q      <= ex_to_dc_bus[EX_PC_LO +: 32];
            exc_q     <= ex_to_dc_bus[EX_EXC_LO +: 32];
        end
    end

    dc_store_lane u_lane (
        .mem_op     (op_q),
        .addr       (addr_q),
        .store_data (sdata_q),
        .size       (lane_size),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned)
    );

    always_comb begin
        exc_out   = exc_q;
        bad_vaddr = '0;
        if (misaligned) begin
            bad_vaddr = addr_q;
            if (is_load) begin
                exc_out[EXC_ADEL_BIT] = 1'b1;
            end
            if (is_store) begin
                exc_out[EXC_ADES_BIT] = 1'b1;
            end
        end
    end

    assign access = (op_q != '0) && (exc_q == '0) && !misaligned;
    assign need   = access && !served;
    // A flushed instruction must never start a transaction, stores above all.
    assign issue  = need && !flush;

    always_comb begin
        data_req    = 1'b0;
        stallreq_dc = 1'b0;
        case (state)
            ST_IDLE: begin
                data_req    = issue;
                stallreq_dc = need;
            end
            ST_REQ: begin
                data_req    = 1'b1;
                stallreq_dc = 1'b1;
            end
            ST_WAIT:  stallreq_dc = ~data_data_ok;
            ST_DRAIN: stallreq_dc = access;
            default: begin
                data_req    = 1'b0;
                stallreq_dc = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            served    <= 1'b0;
            rdata_buf <= '0;
        end else begin
            if (flush || advance || bubble) begin
                served <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= data_addr_ok ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        state <= data_addr_ok ? ST_DRAIN : ST_IDLE;
                    end else if (data_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        rdata_buf <= data_rdata;
                        if (flush || advance) begin
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_HOLD;
                            served <= ~bubble;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (flush || advance) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (data_data_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign data_wr       = is_store;
    assign data_size     = lane_size;
    assign data_addr     = addr_q;
    assign data_wstrb    = lane_wstrb;
    assign data_wdata    = lane_wdata;
    assign dc_to_mem_bus = {payload_q, pc_q, bad_vaddr, exc_out};
    assign dc_rdata      = data_data_ok ? data_rdata : rdata_buf;

endmodule

// File: tb/tb_dc_access.sv
// Directed bench for dc_access: vector table for decode/alignment plus
// hand sequences for latency, drain, hold and async reset.
module tb_dc_access;

    localparam int PW     = 178;
    localparam int BUS_IN = PW + 168;
    localparam int BUS_OUT = PW + 96;

    localparam logic [7:0] OP_LB = 8'h80, OP_LBU = 8'h40, OP_LH = 8'h20, OP_LHU = 8'h10;
    localparam logic [7:0] OP_LW = 8'h08, OP_SB = 8'h04, OP_SH = 8'h02, OP_SW = 8'h01;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [7:0]        stall;
    logic [BUS_IN-1:0] ex_to_dc_bus;
    logic [BUS_OUT-1:0] dc_to_mem_bus;
    logic              stallreq_dc;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [31:0]       data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic [31:0]       dc_rdata;

    int total = 0;
    int bad   = 0;

    dc_access #(.PAYLOAD_WD(PW), .STALL_IDX(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .ex_to_dc_bus  (ex_to_dc_bus),
        .dc_to_mem_bus (dc_to_mem_bus),
        .stallreq_dc   (stallreq_dc),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wstrb    (data_wstrb),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .dc_rdata      (dc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] sdata;
        logic [31:0] addr;
        logic [31:0] exc;
        logic [31:0] rdata;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exc_o;
        logic [31:0] badv;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pl(input int seed);
        logic [PW-1:0] p;
        for (int b = 0; b < PW; b++) p[b] = ((b * 5 + seed * 3) % 7) < 3;
        return p;
    endfunction

    function automatic logic [BUS_IN-1:0] mk_ex(input logic [PW-1:0] pl, input logic [7:0] op,
                                                input logic [31:0] sd, input logic [31:0] a,
                                                input logic [31:0] pc, input logic [31:0] exc);
        return {pl, 32'h0, op, sd, a, pc, exc};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " bus0"}, 32'(dc_to_mem_bus != '0), 32'd0);
        chk({tag, " stallreq"}, 32'(stallreq_dc), 32'd0);
        chk({tag, " req"}, 32'(data_req), 32'd0);
        chk({tag, " wr"}, 32'(data_wr), 32'd0);
        chk({tag, " size"}, 32'(data_size), 32'd0);
        chk({tag, " addr"}, data_addr, 32'd0);
        chk({tag, " wstrb"}, 32'(data_wstrb), 32'd0);
        chk({tag, " wdata"}, data_wdata, 32'd0);
        chk({tag, " rdata"}, dc_rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] pl;
        logic [31:0]   last_buf;
        logic [31:0]   exp_pc;
        int            n_stall;
        int            n_req;

        v[0]  = '{OP_LW,  32'h0,        32'h8000_1000, 32'h0,   32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h0,    32'h0};
        v[1]  = '{OP_SB,  32'h0000_00A5, 32'h8000_0003, 32'h0,   32'h0,         1'b1, 1'b1, 2'd0, 4'b1000, 32'hA5A5_A5A5, 32'h0,    32'h0};
        v[2]  = '{OP_SB,  32'h1234_5678, 32'h8000_0001, 32'h0,   32'h0,         1'b1, 1'b1, 2'd0, 4'b0010, 32'h7878_7878, 32'h0,    32'h0};
        v[3]  = '{OP_SH,  32'hCAFE_BEEF, 32'h8000_0002, 32'h0,   32'h0,         1'b1, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0,    32'h0};
        v[4]  = '{OP_SH,  32'h0000_1234, 32'h8000_0000, 32'h0,   32'h0,         1'b1, 1'b1, 2'd1, 4'b0011, 32'h1234_1234, 32'h0,    32'h0};
        v[5]  = '{OP_SW,  32'h1122_3344, 32'h8000_0004, 32'h0,   32'h0,         1'b1, 1'b1, 2'd2, 4'b1111, 32'h1122_3344, 32'h0,    32'h0};
        v[6]  = '{OP_LH,  32'h0,        32'h8000_0001, 32'h0,   32'h0,         1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h8000, 32'h8000_0001};
        v[7]  = '{OP_LHU, 32'h0,        32'h8000_0002, 32'h0,   32'h0000_BEEF, 1'b1, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h0,    32'h0};
        v[8]  = '{OP_LW,  32'h0,        32'h8000_0006, 32'h0,   32'h0,         1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h8000, 32'h8000_0006};
        v[9]  = '{OP_SW,  32'h5566_7788, 32'h8000_0002, 32'h0,   32'h0,         1'b0, 1'b1, 2'd2, 4'b1111, 32'h5566_7788, 32'h4000, 32'h8000_0002};
        v[10] = '{OP_SH,  32'h0000_ABCD, 32'h8000_0003, 32'h0,   32'h0,         1'b0, 1'b1, 2'd1, 4'b1100, 32'hABCD_ABCD, 32'h4000, 32'h8000_0003};
        v[11] = '{OP_LB,  32'h0,        32'h8000_0003, 32'h0,   32'h0000_00EE, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,    32'h0};
        v[12] = '{OP_LBU, 32'h0,        32'h8000_0000, 32'h400, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h400,  32'h0};
        v[13] = '{8'h00,  32'hFFFF_FFFF, 32'h0000_1234, 32'h0,   32'h0,         1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,    32'h0};
        v[14] = '{OP_LW,  32'h0,        32'h8000_0001, 32'h10,  32'h0,         1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h8010, 32'h8000_0001};

        rst = 1'b0; flush = 1'b0; stall = 8'h00; ex_to_dc_bus = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        last_buf = '0;

        // reset state
        #3;
        chk_zero("reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;

        // vector table
        for (int i = 0; i < NV; i++) begin
            pl = mk_pl(i);
            exp_pc = 32'h0040_0000 + 32'(i * 4);
            ex_to_dc_bus = mk_ex(pl, v[i].op, v[i].sdata, v[i].addr, exp_pc, v[i].exc);
            stall = 8'h00;
            @(posedge clk); #1;
            stall = 8'h7F;
            ex_to_dc_bus = '0;
            @(negedge clk);
            chk($sformatf("v%0d req", i), 32'(data_req), 32'(v[i].req));
            chk($sformatf("v%0d stallreq", i), 32'(stallreq_dc), 32'(v[i].req));
            chk($sformatf("v%0d addr", i), data_addr, v[i].addr);
            chk($sformatf("v%0d exc_out", i), dc_to_mem_bus[31:0], v[i].exc_o);
            chk($sformatf("v%0d bad_vaddr", i), dc_to_mem_bus[63:32], v[i].badv);
            chk($sformatf("v%0d pc", i), dc_to_mem_bus[95:64], exp_pc);
            chk($sformatf("v%0d payload", i), 32'(dc_to_mem_bus[BUS_OUT-1:96] == pl), 32'd1);
            if (v[i].req) begin
                chk($sformatf("v%0d wr", i), 32'(data_wr), 32'(v[i].wr));
                chk($sformatf("v%0d size", i), 32'(data_size), 32'(v[i].size));
                chk($sformatf("v%0d wstrb", i), 32'(data_wstrb), 32'(v[i].wstrb));
                chk($sformatf("v%0d wdata", i), data_wdata, v[i].wdata);
                data_addr_ok = 1'b1;
                @(posedge clk); #1;
                data_addr_ok = 1'b0;
                data_data_ok = 1'b1;
                data_rdata   = v[i].rdata;
                stall        = 8'h00;
                @(negedge clk);
                chk($sformatf("v%0d bypass", i), dc_rdata, v[i].rdata);
                chk($sformatf("v%0d stallreq_ok", i), 32'(stallreq_dc), 32'd0);
                chk($sformatf("v%0d req_wait", i), 32'(data_req), 32'd0);
                @(posedge clk); #1;
                data_data_ok = 1'b0;
                data_rdata   = 32'h0BAD_0BAD;
                last_buf     = v[i].rdata;
                @(negedge clk);
                chk($sformatf("v%0d buffered", i), dc_rdata, last_buf);
            end else begin
                stall = 8'h00;
                @(posedge clk); #1;
            end
        end

        // lw with addr_ok at once, data_ok after three wait cycles
        pl = mk_pl(20);
        ex_to_dc_bus = mk_ex(pl, OP_LW, 32'h0, 32'h8000_1000, 32'hBFC0_0100, 32'h0);
        stall = 8'h00;
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0; data_addr_ok = 1'b1;
        n_stall = 0; n_req = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; stall = 8'h00;
            end
            @(negedge clk);
            if (stallreq_dc) n_stall++;
            if (data_req) n_req++;
            if (c == 4) chk("lat rdata", dc_rdata, 32'hDEAD_BEEF);
            @(posedge clk); #1;
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
        end
        chk("lat stall cycles", 32'(n_stall), 32'd4);
        chk("lat req pulses", 32'(n_req), 32'd1);
        last_buf = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lat idle req", 32'(data_req), 32'd0);

        // flush in WAIT -> DRAIN; new sw waits for the orphaned data_ok
        ex_to_dc_bus = mk_ex(mk_pl(21), OP_LW, 32'h0, 32'h8000_2000, 32'hBFC0_0200, 32'h0);
        stall = 8'h00;
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0; data_addr_ok = 1'b1;
        @(negedge clk);
        chk("drn issue", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("drn wait stall", 32'(stallreq_dc), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; stall = 8'h00;
        ex_to_dc_bus = mk_ex(mk_pl(22), OP_SW, 32'hCAFE_F00D, 32'h8000_3000, 32'hBFC0_0300, 32'h0);
        @(negedge clk);
        chk("drn empty stall", 32'(stallreq_dc), 32'd0);
        chk("drn empty req", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0;
        data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        @(negedge clk);
        chk("drn sw req", 32'(data_req), 32'd0);
        chk("drn sw stall", 32'(stallreq_dc), 32'd1);
        @(posedge clk); #1;
        data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        chk("drn discard", dc_rdata, last_buf);
        chk("drn sw issue", 32'(data_req), 32'd1);
        chk("drn sw wr", 32'(data_wr), 32'd1);
        chk("drn sw stall2", 32'(stallreq_dc), 32'd1);
        chk("drn sw wdata", data_wdata, 32'hCAFE_F00D);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0; stall = 8'h00;
        @(negedge clk);
        chk("drn sw done", 32'(stallreq_dc), 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        last_buf = 32'h0;

        // load completes while MEM is stalled -> HOLD, no re-issue
        ex_to_dc_bus = mk_ex(mk_pl(23), OP_LW, 32'h0, 32'h8000_4000, 32'hBFC0_0400, 32'h0);
        stall = 8'h00;
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1357_2468;
        @(negedge clk);
        chk("hold bypass", dc_rdata, 32'h1357_2468);
        chk("hold ok stall", 32'(stallreq_dc), 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d req", c), 32'(data_req), 32'd0);
            chk($sformatf("hold%0d stall", c), 32'(stallreq_dc), 32'd0);
            chk($sformatf("hold%0d rdata", c), dc_rdata, 32'h1357_2468);
            @(posedge clk); #1;
        end
        stall = 8'h00;
        @(negedge clk);
        chk("hold adv req", 32'(data_req), 32'd0);
        chk("hold pc", dc_to_mem_bus[95:64], 32'hBFC0_0400);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold after req", 32'(data_req), 32'd0);
        chk("hold after pc", dc_to_mem_bus[95:64], 32'h0);

        // asynchronous reset in the middle of WAIT
        ex_to_dc_bus = mk_ex(mk_pl(24), OP_SW, 32'h7777_8888, 32'h8000_5000, 32'hBFC0_0500, 32'h1);
        ex_to_dc_bus[31:0] = 32'h0;
        stall = 8'h00;
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rst pre stall", 32'(stallreq_dc), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst async");
        stall = 8'h00;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst idle req", 32'(data_req), 32'd0);
        chk("rst idle stall", 32'(stallreq_dc), 32'd0);
        ex_to_dc_bus = mk_ex(mk_pl(25), OP_LW, 32'h0, 32'h8000_6000, 32'hBFC0_0600, 32'h0);
        @(posedge clk); #1;
        stall = 8'h7F; ex_to_dc_bus = '0;
        @(negedge clk);
        chk("rst new req", 32'(data_req), 32'd1);
        chk("rst new addr", data_addr, 32'h8000_6000);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2468_ACE0; stall = 8'h00;
        @(negedge clk);
        chk("rst new rdata", dc_rdata, 32'h2468_ACE0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
